// File: rtl/espsid_pkg.sv
// Shared definitions for the espSID return path.
//   - SID read-only register addresses swept by sid_readback.
//   - Sweep FSM state encoding.
//   - SPI mode of the MISO transmitter (mode 0: master samples on sclk rise).
package espsid_pkg;

    localparam logic [4:0] POTX = 5'h19;
    localparam logic [4:0] POTY = 5'h1A;
    localparam logic [4:0] OSC3 = 5'h1B;
    localparam logic [4:0] ENV3 = 5'h1C;

    localparam int SPI_MODE = 0;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        SETUP,
        ACCESS,
        DONE
    } sweep_state_t;

endpackage

// File: rtl/spi_tx_shift.sv
// SPI slave transmitter for the SID readback snapshot.
// Synchronises ss and sclk into the clk domain, detects their edges and
// shifts a parallel word out on miso, MSB first.
// Ports:
//   clk, rst   : CPLD clock, synchronous active-high reset
//   ss         : SPI slave select (active low), asynchronous to clk
//   sclk       : SPI clock, asynchronous to clk
//   load_data  : word captured into the shift register on ss fall
//   ss_rise    : one-clk pulse when the synchronised ss goes high
//   miso       : serial data out
//   miso_oe    : high while the (synchronised) ss is low
module spi_tx_shift
    import espsid_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int WIDTH       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ss,
    input  logic             sclk,
    input  logic [WIDTH-1:0] load_data,
    output logic             ss_rise,
    output logic             miso,
    output logic             miso_oe
);

    // Mode 0 master samples on the rising edge, so the slave moves to the
    // next bit on the falling edge.
    localparam bit SHIFT_ON_FALL = (SPI_MODE == 0);

    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic                   ss_prev;
    logic                   sclk_prev;
    logic                   ss_s;
    logic                   sclk_s;
    logic                   ss_fall;
    logic                   sclk_fall;
    logic                   sclk_rise;
    logic                   shift_edge;
    logic [WIDTH-1:0]       shreg;

    assign ss_s       = ss_sync[SYNC_STAGES-1];
    assign sclk_s     = sclk_sync[SYNC_STAGES-1];
    assign ss_fall    = ss_prev & ~ss_s;
    assign ss_rise    = ~ss_prev & ss_s;
    assign sclk_fall  = sclk_prev & ~sclk_s;
    assign sclk_rise  = ~sclk_prev & sclk_s;
    assign shift_edge = SHIFT_ON_FALL ? sclk_fall : sclk_rise;

    // Synchronisers reset to the idle levels (ss high, sclk low) so leaving
    // reset never looks like a frame start or a clock edge.
    // NOTE: sequential state uses non-blocking assignments so every flop in
    // the chain samples the value from before this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ss_sync   <= '1;
            sclk_sync <= '0;
            ss_prev   <= 1'b1;
            sclk_prev <= 1'b0;
        end else begin
            ss_sync   <= SYNC_STAGES'({ss_sync, ss});
            sclk_sync <= SYNC_STAGES'({sclk_sync, sclk});
            ss_prev   <= ss_s;
            sclk_prev <= sclk_s;
        end
    end

    // miso is the MSB of the shift register itself; clearing the register
    // on reset or ss rise forces miso low, and the zero fill makes every bit
    // after the last data bit read as 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg   <= '0;
            miso_oe <= 1'b0;
        end else if (ss_rise) begin
            shreg   <= '0;
            miso_oe <= 1'b0;
        end else if (ss_fall) begin
            shreg   <= load_data;
            miso_oe <= 1'b1;
        end else if (shift_edge && !ss_s) begin
            shreg   <= {shreg[WIDTH-2:0], 1'b0};
        end
    end

    assign miso = shreg[WIDTH-1];

endmodule

// File: rtl/sid_readback.sv
// SID -> ESP8266 return path.
// After every SPI frame (ss rise) this block requests the SID bus, runs one
// read cycle per register starting at FIRST_ADDR, and stores the bytes as a
// snapshot. The next SPI frame shifts that snapshot out on miso.
// Ports:
//   clk, rst     : 20 MHz CPLD clock, synchronous active-high reset
//   sid_clk      : 1 MHz phi2, generated in the clk domain
//   bus_req      : request for the SID addr/data/cs/rw lines
//   bus_gnt      : grant, held until bus_req drops
//   sid_addr     : SID register address during a read
//   sid_data_in  : SID data bus
//   sid_cs       : SID chip select, active low
//   sid_rw       : SID read/write, always 1 (read)
//   ss, sclk     : SPI slave select and clock (shared with spi_slave)
//   miso, miso_oe: SPI serial out and its output enable
//   snap_valid   : a sweep has completed since reset
module sid_readback
    import espsid_pkg::*;
#(
    parameter logic [4:0] FIRST_ADDR  = POTX,
    parameter int         NUM_REGS    = 4,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sid_clk,
    output logic       bus_req,
    input  logic       bus_gnt,
    output logic [4:0] sid_addr,
    input  logic [7:0] sid_data_in,
    output logic       sid_cs,
    output logic       sid_rw,
    input  logic       ss,
    input  logic       sclk,
    output logic       miso,
    output logic       miso_oe,
    output logic       snap_valid
);

    localparam int                SNAP_W   = 8 * NUM_REGS;
    localparam int                IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_REGS - 1);

    sweep_state_t      state;
    sweep_state_t      state_n;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_n;
    logic              req_n;
    logic              cs_n;
    logic [4:0]        addr_n;
    logic              cap_we;
    logic              snap_load;
    logic              sid_prev;
    logic              sid_fall;
    logic              ss_rise;
    logic [7:0]        capture [NUM_REGS];
    logic [SNAP_W-1:0] capture_flat;
    logic [SNAP_W-1:0] snapshot;

    // This block only ever reads the SID.
    assign sid_rw   = 1'b1;
    assign sid_fall = sid_prev & ~sid_clk;

    // Next-state and registered-output logic for the sweep FSM.
    // NOTE: every signal gets a default before the case so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    always_comb begin
        state_n   = state;
        idx_n     = idx;
        req_n     = bus_req;
        cs_n      = sid_cs;
        addr_n    = sid_addr;
        cap_we    = 1'b0;
        snap_load = 1'b0;
        case (state)
            IDLE: begin
                if (ss_rise) begin
                    state_n = REQ;
                    req_n   = 1'b1;
                end
            end
            REQ: begin
                if (bus_gnt) begin
                    state_n = SETUP;
                    idx_n   = '0;
                end
            end
            SETUP: begin
                // Address and cs change just after phi2 falls, so they are
                // stable through the whole following phi2 high phase.
                if (sid_fall) begin
                    addr_n  = FIRST_ADDR + 5'(idx);
                    cs_n    = 1'b0;
                    state_n = ACCESS;
                end
            end
            ACCESS: begin
                if (sid_fall) begin
                    cap_we = 1'b1;
                    cs_n   = 1'b1;
                    if (idx == LAST_IDX) begin
                        state_n = DONE;
                    end else begin
                        idx_n   = idx + 1'b1;
                        state_n = SETUP;
                    end
                end
            end
            DONE: begin
                snap_load = 1'b1;
                req_n     = 1'b0;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            bus_req    <= 1'b0;
            sid_cs     <= 1'b1;
            sid_addr   <= '0;
            sid_prev   <= 1'b0;
            snapshot   <= '0;
            snap_valid <= 1'b0;
        end else begin
            state    <= state_n;
            idx      <= idx_n;
            bus_req  <= req_n;
            sid_cs   <= cs_n;
            sid_addr <= addr_n;
            sid_prev <= sid_clk;
            if (snap_load) begin
                snapshot   <= capture_flat;
                snap_valid <= 1'b1;
            end
        end
    end

    // NOTE: the capture bytes carry no reset; a sweep writes every entry
    // before DONE copies them, and snapshot itself is reset to zero.
    always_ff @(posedge clk) begin
        if (cap_we) begin
            capture[idx] <= sid_data_in;
        end
    end

    // The byte read from FIRST_ADDR goes in the top byte so it leaves first.
    always_comb begin
        capture_flat = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            capture_flat[SNAP_W-1-8*i -: 8] = capture[i];
        end
    end

    spi_tx_shift #(
        .SYNC_STAGES (SYNC_STAGES),
        .WIDTH       (SNAP_W)
    ) u_tx (
        .clk       (clk),
        .rst       (rst),
        .ss        (ss),
        .sclk      (sclk),
        .load_data (snapshot),
        .ss_rise   (ss_rise),
        .miso      (miso),
        .miso_oe   (miso_oe)
    );

endmodule

// File: doc/sid_readback.md
Name: sid_readback

Overview:
- Return path from the SID to the ESP8266.
- After every SPI frame ends (ss rises), arbitrates for the SID bus and runs real SID read cycles on the read-only registers 0x19–0x1C (POTX, POTY, OSC3, ENV3). Stores them as a 32-bit snapshot.
- On the next frame, shifts that snapshot out on MISO as an SPI mode-0 slave transmitter.
- Sits beside spi_slave and sid_glue in espSID_top. Shares ss/sclk with spi_slave and the SID bus with sid_glue through a req/gnt pair.

Parameters:
- FIRST_ADDR, 5'h19, SID address of the first register read.
- NUM_REGS, 4, registers per sweep; snapshot width = 8*NUM_REGS.
- SYNC_STAGES, 2, flip-flop stages on ss and sclk before edge detection.

Ports:
- clk  in  1  20 MHz CPLD clock.
- rst  in  1  synchronous, active-high reset.
- sid_clk  in  1  1 MHz phi2 from clock_divider (same clk domain, no sync).
- bus_req  out  1  request ownership of SID addr/data/cs/rw.
- bus_gnt  in  1  ownership granted; held until bus_req drops.
- sid_addr  out  5  SID address during read.
- sid_data_in  in  8  SID data bus (top tristates its own driver while gnt).
- sid_cs  out  1  active-low chip select.
- sid_rw  out  1  1 = read.
- ss  in  1  SPI slave select, active low.
- sclk  in  1  SPI clock.
- miso  out  1  serial data out.
- miso_oe  out  1  1 while ss low; top drives Z otherwise.
- snap_valid  out  1  at least one sweep has completed since reset.

Behaviour:
- Reset values: bus_req=0, sid_cs=1, sid_rw=1, sid_addr=0, miso=0, miso_oe=0, snap_valid=0, snapshot=0, FSM=IDLE. Reset mid-sweep or mid-frame aborts the sweep or frame. cs is high on the first clk after reset.
- ss and sclk pass through SYNC_STAGES flip-flops. Edges are detected on the synchronised copies:
  - ss_fall / ss_rise from the synchronised ss.
  - sclk_fall from the synchronised sclk.
  - sid_fall = previous sid_clk high and current sid_clk low.
- Sweep FSM states:
  - IDLE: on ss_rise go to REQ.
  - REQ: bus_req=1; on bus_gnt go to SETUP, with idx=0.
  - SETUP: wait for sid_fall. On that clk drive sid_addr=FIRST_ADDR+idx, sid_cs=0, sid_rw=1, then go to ACCESS.
  - ACCESS: hold addr/cs/rw through one full phi2 high phase. On the next sid_fall, capture sid_data_in into capture[idx] and set sid_cs=1. If idx=NUM_REGS-1 go to DONE, else idx+1 and go to SETUP.
  - DONE: copy capture into snapshot atomically, set snap_valid=1, bus_req=0, go to IDLE.
- Sweep timing: at most 2*NUM_REGS+1 sid_clk periods after grant, ≤9 µs at default.
- ss_rise while not IDLE is ignored; no sweep is queued.
- bus_req stays high from REQ through DONE. sid_cs is never low unless bus_gnt is high.
- Transmitter:
  - On ss_fall, load shift register from snapshot; miso=bit[MSB], miso_oe=1.
  - Byte order: the byte read from FIRST_ADDR is sent first, MSB first.
  - On each sclk_fall while ss is low, shift left with 0 fill and update miso. The master samples on sclk rise (mode 0).
  - After 32 bits, miso=0 for any further clocks.
  - On ss_rise, miso_oe=0 and miso=0.
- A sweep completing while ss is low updates snapshot only. The current frame keeps the data loaded at ss_fall, so the transmitted frame is always coherent.
- A frame starting before the first sweep sends 32 zeros (snap_valid=0).
- Synchroniser and edge-detection latency: ss_fall to valid miso within SYNC_STAGES+2 clk. Maximum sclk is therefore clk/8 = 2.5 MHz.

Decomposition:
- Shared package espsid_pkg holds:
  - SID register constants: POTX=5'h19, POTY=5'h1A, OSC3=5'h1B, ENV3=5'h1C.
  - Sweep FSM state encoding (IDLE, REQ, SETUP, ACCESS, DONE).
  - SPI_MODE=0.
- One natural sub-module, spi_tx_shift: synchronisers, edge detection, and the shift register driving miso/miso_oe. The sweep FSM stays in sid_readback.

Test Plan:
- Reset with ss high, then pulse ss low for 32 sclk at 1 MHz → miso shows 32 zeros; snap_valid=0; bus_req stays 0 during the frame.
- After that ss_rise, grant bus_req after 5 clk; SID model returns 8'h12, 8'h34, 8'h56, 8'h78 for 0x19–0x1C → four cs-low windows, each exactly 20 clk long and aligned to sid_clk falling edges. Addresses are 19, 1A, 1B, 1C with rw=1; snap_valid=1; bus_req drops after the fourth capture.
- Next frame, 32 sclk → master samples 32'h12345678; 8 extra sclk → 8 zeros.
- Drop ss low during the second register access of a sweep, with the model changing data to 8'hAA..DD → the frame carries the old 32'h12345678; the frame after it carries 32'hAABBCCDD.
- Hold bus_gnt low for 100 clk → sid_cs stays 1 and bus_req stays 1 throughout; the sweep starts on the first grant.
- Assert rst while in ACCESS with cs low → next clk shows sid_cs=1, bus_req=0, snap_valid=0; the next frame sends zeros.
